// File: rtl/stream_interp.sv
// ============================================================================
// stream_interp : AXI-Stream sample repeater / zero-stuffing interpolator
// Revision      : 1.0
// ============================================================================
`default_nettype none

module stream_interp #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           interp,
  input  logic                  zero_stuff,
  input  logic [DATA_WIDTH-1:0] stream_i_tdata,
  input  logic                  stream_i_tvalid,
  output logic                  stream_i_tready,
  output logic [DATA_WIDTH-1:0] stream_o_tdata,
  output logic                  stream_o_tvalid,
  input  logic                  stream_o_tready,
  output logic                  stream_o_tlast
);

  localparam logic [31:0] C_ONE = 32'd1;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           n_q, n_d;
  logic                  zs_q, zs_d;
  logic                  full_q, full_d;

  logic w_last;
  logic w_in_hs;
  logic w_out_hs;

  assign w_last   = (cnt_q == n_q);
  assign w_in_hs  = stream_i_tvalid && stream_i_tready;
  assign w_out_hs = full_q && stream_o_tready;

  // Accepting a new sample is only allowed once the final repetition leaves.
  assign stream_i_tready = !full_q || (stream_o_tready && w_last);
  assign stream_o_tvalid = full_q;
  assign stream_o_tlast  = full_q && w_last;
  assign stream_o_tdata  = ((cnt_q == C_ONE) || !zs_q) ? data_q : '0;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    n_d    = n_q;
    zs_d   = zs_q;
    full_d = full_q;
    if (w_in_hs) begin
      data_d = stream_i_tdata;
      n_d    = (interp == 32'd0) ? C_ONE : interp;
      zs_d   = zero_stuff;
      cnt_d  = C_ONE;
      full_d = 1'b1;
    end else if (w_out_hs) begin
      if (w_last) begin
        full_d = 1'b0;
      end else begin
        cnt_d = cnt_q + C_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= C_ONE;
      n_q    <= C_ONE;
      zs_q   <= 1'b0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      n_q    <= n_d;
      zs_q   <= zs_d;
      full_q <= full_d;
    end
  end

endmodule

`default_nettype wire
